// File: rtl/issue_unit.sv
// issue_unit: grants one of four issue queues per cycle while booking the
// shared CDB write slot each instruction will need and tracking the divider.
// Ports: Clk, Rst_n (async, active-low); Issue*_Ready requests from the
// Int/Ls/Mult/Div queues; RB_Flush_Valid discards all in-flight work;
// Issue_* same-cycle grants; Div_Busy divider occupied; Cdb_Resv[j] = CDB
// booked j+1 cycles ahead.
// Build option: define ISSUE_RR_EN for round-robin arbitration in the order
// Div, Mult, Ls, Int; otherwise fixed priority Div > Mult > Ls > Int.
module issue_unit (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       IssueInt_Ready,
    input  logic       IssueLs_Ready,
    input  logic       IssueMult_Ready,
    input  logic       IssueDiv_Ready,
    input  logic       RB_Flush_Valid,
    output logic       Issue_Int,
    output logic       Issue_Ls,
    output logic       Issue_Mult,
    output logic       Issue_Div,
    output logic       Div_Busy,
    output logic [6:0] Cdb_Resv
);

    // Request/grant vectors are ordered {div, mult, ls, int}.
    logic [3:0] elig;
    logic [3:0] grant;
    logic [2:0] div_cnt;
    logic       gate;

    assign Div_Busy = (div_cnt != 3'd0);

    // Grants are suppressed while reset is held so the outputs are quiet
    // without waiting for a clock edge.
    assign gate = Rst_n & ~RB_Flush_Valid;

    // Each unit checks the slot its fixed latency lands on.
    always_comb begin
        elig    = '0;
        elig[3] = IssueDiv_Ready  & ~Cdb_Resv[6] & ~Div_Busy;
        elig[2] = IssueMult_Ready & ~Cdb_Resv[3];
        elig[1] = IssueLs_Ready   & ~Cdb_Resv[1];
        elig[0] = IssueInt_Ready  & ~Cdb_Resv[0];
    end

`ifdef ISSUE_RR_EN
    // Order index 0..3 = Div, Mult, Ls, Int.
    logic [3:0] elig_ord;
    logic [1:0] rr_ptr;
    logic [1:0] idx;
    logic [1:0] win;
    logic       found;

    assign elig_ord = {elig[0], elig[1], elig[2], elig[3]};

    always_comb begin
        found = 1'b0;
        win   = rr_ptr;
        idx   = rr_ptr;
        for (int i = 0; i < 4; i++) begin
            idx = rr_ptr + 2'(i);
            if (!found && gate && elig_ord[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        grant = found ? (4'b1000 >> win) : 4'b0000;
    end

    // Pointer moves past the winner, only when something was granted.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rr_ptr <= 2'd0;
        end else if (found) begin
            rr_ptr <= win + 2'd1;
        end
    end
`else
    always_comb begin
        grant = 4'b0000;
        if (gate) begin
            priority case (1'b1)
                elig[3]: grant = 4'b1000;
                elig[2]: grant = 4'b0100;
                elig[1]: grant = 4'b0010;
                elig[0]: grant = 4'b0001;
                default: grant = 4'b0000;
            endcase
        end
    end
`endif

    assign Issue_Div  = grant[3];
    assign Issue_Mult = grant[2];
    assign Issue_Ls   = grant[1];
    assign Issue_Int  = grant[0];

    // A grant of latency L books bit L-2 of the shifted vector:
    // Div -> 5, Mult -> 2, Ls -> 0; Int writes next cycle, needs no booking.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Cdb_Resv <= '0;
            div_cnt  <= '0;
        end else if (RB_Flush_Valid) begin
            Cdb_Resv <= '0;
            div_cnt  <= '0;
        end else begin
            Cdb_Resv <= (Cdb_Resv >> 1) |
                        {1'b0, grant[3], 2'b00, grant[2], 1'b0, grant[1]};
            if (grant[3]) begin
                div_cnt <= 3'd6;
            end else if (div_cnt != 3'd0) begin
                div_cnt <= div_cnt - 3'd1;
            end
        end
    end

endmodule
